// File: rtl/fetch_unit.sv
// RV64I instruction-fetch stage: credit-limited IM requests, in-order responses, small
// instruction FIFO feeding decode. Define FETCH_PERF_CNT_EN to add performance counters.
module fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_redirect_valid,
  input  logic [63:0] i_redirect_pc,
  output logic        o_im_req_valid,
  input  logic        i_im_req_ready,
  output logic [63:0] o_im_req_addr,
  input  logic        i_im_rsp_valid,
  input  logic [31:0] i_im_rsp_data,
  output logic        o_d_valid,
  output logic [31:0] o_d_inst,
  output logic [63:0] o_d_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [63:0] o_perf_fetched,
  output logic [63:0] o_perf_bubble,
  output logic [31:0] o_perf_dropped
`endif
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  logic [63:0]   r_fetch_pc;
  logic [63:0]   r_rsp_pc;
  logic [63:0]   r_last_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [63:0]   r_fifo_pc   [FIFO_DEPTH];
  logic [31:0]   r_fifo_inst [FIFO_DEPTH];

  logic [CW:0]   w_credit_sum;
  logic          w_req_fire;
  logic          w_rsp_ok;
  logic          w_rsp_drop;
  logic          w_push;
  logic          w_pop;
  logic          w_d_valid;
  logic [63:0]   w_redirect_aligned;
  logic [CW-1:0] w_outstanding_d;
  logic [CW-1:0] w_drop_cnt_d;
  logic [CW-1:0] w_count_d;
  logic          w_unused_pc_lsb;

  assign w_redirect_aligned = {i_redirect_pc[63:2], 2'b00};
  assign w_unused_pc_lsb    = ^i_redirect_pc[1:0];

  // Requests in flight plus buffered entries never exceed the FIFO size.
  assign w_credit_sum   = {1'b0, r_outstanding} + {1'b0, r_count};
  assign o_im_req_valid = rst && (w_credit_sum < DEPTH_W) && !i_redirect_valid;
  assign o_im_req_addr  = r_fetch_pc;
  assign w_req_fire     = o_im_req_valid && i_im_req_ready;

  assign w_rsp_ok   = i_im_rsp_valid && (r_outstanding != '0);
  assign w_rsp_drop = w_rsp_ok && (i_redirect_valid || (r_drop_cnt != '0));
  assign w_push     = w_rsp_ok && !w_rsp_drop;

  assign w_d_valid = (r_count != '0);
  assign w_pop     = w_d_valid && !i_stall && !i_redirect_valid;

  assign o_d_valid = w_d_valid;
  assign o_d_inst  = w_d_valid ? r_fifo_inst[r_rd_ptr] : NOP_INST;
  assign o_d_pc    = w_d_valid ? r_fifo_pc[r_rd_ptr] : r_last_pc;

  always_comb begin
    w_outstanding_d = r_outstanding;
    if (w_req_fire) w_outstanding_d = w_outstanding_d + ONE_C;
    if (w_rsp_ok)   w_outstanding_d = w_outstanding_d - ONE_C;

    w_drop_cnt_d = r_drop_cnt;
    if (i_redirect_valid) begin
      // Every request still in flight after this cycle belongs to the old path.
      w_drop_cnt_d = w_rsp_ok ? (r_outstanding - ONE_C) : r_outstanding;
    end else if (w_rsp_drop) begin
      w_drop_cnt_d = r_drop_cnt - ONE_C;
    end

    w_count_d = r_count;
    if (i_redirect_valid) begin
      w_count_d = '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   w_count_d = r_count + ONE_C;
        2'b01:   w_count_d = r_count - ONE_C;
        default: w_count_d = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_last_pc     <= 64'h0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_outstanding <= w_outstanding_d;
      r_drop_cnt    <= w_drop_cnt_d;
      r_count       <= w_count_d;
      r_last_pc     <= o_d_pc;
      if (i_redirect_valid) begin
        r_fetch_pc <= w_redirect_aligned;
        // First surviving response is the first request issued at the target.
        r_rsp_pc   <= w_redirect_aligned;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + 64'd4;
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + 64'd4;
          r_wr_ptr <= r_wr_ptr + ONE_P;
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + ONE_P;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]   <= r_rsp_pc;
      r_fifo_inst[r_wr_ptr] <= i_im_rsp_data;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [63:0] r_perf_fetched;
  logic [63:0] r_perf_bubble;
  logic [31:0] r_perf_dropped;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetched <= 64'h0;
      r_perf_bubble  <= 64'h0;
      r_perf_dropped <= 32'h0;
    end else begin
      if (w_pop)      r_perf_fetched <= r_perf_fetched + 64'd1;
      if (!w_d_valid) r_perf_bubble  <= r_perf_bubble + 64'd1;
      if (w_rsp_drop) r_perf_dropped <= r_perf_dropped + 32'd1;
    end
  end

  assign o_perf_fetched = r_perf_fetched;
  assign o_perf_bubble  = r_perf_bubble;
  assign o_perf_dropped = r_perf_dropped;
`endif

  assert property (@(posedge clk) disable iff (!rst) i_im_rsp_valid |-> (r_outstanding != '0));

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the RV64I 5-stage pipeline; the stage directly upstream of decode and the pipeline controller.
- Owns the fetch PC and issues requests to instruction memory over a valid/ready request channel with in-order, variable-latency responses.
- Buffers returned instructions in a small FIFO and presents one instruction per cycle to decode.
- Honours the controller's load-use stall (hold) and its taken-branch/jump redirect (flush).

Parameters:
RESET_PC, 64'h0, fetch PC loaded on reset.
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2); also the cap on requests in flight plus buffered entries.
NOP_INST, 32'h00000013, instruction presented on D_inst when D_valid=0 (addi x0,x0,0).

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
stall  in  1  controller load-use stall; hold decode output
redirect_valid  in  1  taken branch/JAL/JALR resolved in E (controller next_pc_sel == TARGET)
redirect_pc  in  64  redirect target
im_req_valid  out  1  IM read request valid
im_req_ready  in  1  IM accepts request
im_req_addr  out  64  IM read address, word aligned
im_rsp_valid  in  1  IM read data valid, in request order
im_rsp_data  in  32  IM read data
D_valid  out  1  D_inst/D_pc hold a real instruction
D_inst  out  32  instruction to decode
D_pc  out  64  PC of D_inst

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
  - D_valid=0, D_inst=NOP_INST, D_pc=0, im_req_valid=0.
- Issue:
  - im_req_valid=1 when (outstanding + fifo_count) < FIFO_DEPTH and redirect_valid=0; im_req_addr=fetch_pc.
  - On valid&ready: fetch_pc += 4 (64-bit wrap), outstanding++.
  - An unaccepted request may be withdrawn only by a redirect.
- Response:
  - im_rsp_valid with drop_cnt>0: discard, drop_cnt--, outstanding--.
  - Otherwise push {pc, data} into the FIFO and decrement outstanding.
  - PC is tracked internally per request; no address is echoed by IM.
  - Minimum latency: request accepted in cycle t -> response in t+1 or later -> D_valid at the next edge after the response (no bypass).
- Decode output:
  - D_* is the FIFO head.
  - Pop when D_valid=1 and stall=0.
  - When the FIFO is empty: D_valid=0, D_inst=NOP_INST, D_pc holds its last value.
- Redirect (same cycle):
  - fetch_pc <= {redirect_pc[63:2],2'b00}.
  - FIFO flushed; D_valid=0 from the next cycle.
  - drop_cnt <= outstanding minus any response accepted that cycle; outstanding unchanged.
  - No request is issued and no pop occurs that cycle.
  - A response arriving in the redirect cycle is discarded.
- Priority: reset > redirect > stall > normal.
  - Redirect with stall=1 still flushes; stall only blocks the pop.
- Boundaries:
  - Simultaneous push and pop with the FIFO full is legal; the credit rule keeps occupancy <= FIFO_DEPTH.
  - A response with outstanding=0 is an error (assertion).
  - fetch_pc 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs perf_fetched (64, count of instructions popped to decode), perf_bubble (64, cycles with D_valid=0 and rst=1) and perf_dropped (32, count of discarded responses). All reset to 0 and wrap.
- Undefined: these ports and counters are absent; the remaining behaviour is identical.

Test Plan:
- Reset release, IM ready=1, 1-cycle latency, mem[0]=32'h00500093 -> im_req_addr 0,4,8…; D_valid at cycle 2, D_inst=32'h00500093, D_pc=0; then one instruction per cycle.
- stall=1 held for 3 cycles while D_pc=8 -> D_pc stays 8 and D_inst stays stable; no more than FIFO_DEPTH requests in flight; on stall release D_pc 8,12,16 on consecutive cycles.
- Latency 3 cycles, two requests outstanding, redirect_valid=1 with redirect_pc=0x100 -> both in-flight responses discarded; next D_valid instruction has D_pc=0x100; D_valid=0 meanwhile.
- redirect_pc=0x203 -> im_req_addr=0x200; redirect in the same cycle as im_rsp_valid -> that response never appears on D.
- im_req_ready=0 for 4 cycles -> im_req_addr held at the same value; redirect during the hold -> address switches to the target; the old request is never counted.
- Assert rst=0 mid-stream with 2 outstanding -> D_valid=0 and D_inst=NOP_INST immediately; after release, fetch restarts at RESET_PC; late stale responses are not asserted by the bench model.
